// File: rtl/reg_wr_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered register-file write port.
// Optional macro REGARB_BYPASS_EN adds Rs/Rt read-data forwarding from the pending write.
module reg_wr_arbiter #(
    parameter int INIT_PRI = 0,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [4:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [4:0]        b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              wr_stall,
    output logic              regwr,
    output logic [4:0]        WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    output logic [15:0]       wr_count
`ifdef REGARB_BYPASS_EN
    ,
    input  logic [4:0]        RsAddr,
    input  logic [4:0]        RtAddr,
    input  logic [DATA_W-1:0] RsData_in,
    input  logic [DATA_W-1:0] RtData_in,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData
`endif
);

    localparam logic PRI_RST = (INIT_PRI != 0);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // pri_q: 0 = A holds priority, 1 = B holds priority
    logic              pri_q,   pri_d;
    logic              regwr_q, regwr_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [15:0]       cnt_q,   cnt_d;
    logic              a_xfer, b_xfer;

    assign a_ready = ~reset & ~wr_stall & (~pri_q | ~b_valid);
    assign b_ready = ~reset & ~wr_stall & ( pri_q | ~a_valid);
    assign a_xfer  = a_valid & a_ready;
    assign b_xfer  = b_valid & b_ready;

    always_comb begin
        pri_d   = pri_q;
        regwr_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = regwr_q ? sat_inc(cnt_q) : cnt_q;
        if (a_xfer) begin
            pri_d   = 1'b1;
            waddr_d = a_addr;
            wdata_d = a_data;
            regwr_d = (a_addr != 5'd0);
        end else if (b_xfer) begin
            pri_d   = 1'b0;
            waddr_d = b_addr;
            wdata_d = b_data;
            regwr_d = (b_addr != 5'd0);
        end
    end

    // Output stage: a pending write is dropped outright when reset asserts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pri_q   <= PRI_RST;
            regwr_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            pri_q   <= pri_d;
            regwr_q <= regwr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign regwr     = regwr_q;
    assign WriteAddr = waddr_q;
    assign WriteData = wdata_q;
    assign wr_count  = cnt_q;

`ifdef REGARB_BYPASS_EN
    // Forward the write still in flight so readers never see a stale register
    assign RsData = (regwr_q && (RsAddr == waddr_q) && (waddr_q != 5'd0)) ? wdata_q : RsData_in;
    assign RtData = (regwr_q && (RtAddr == waddr_q) && (waddr_q != 5'd0)) ? wdata_q : RtData_in;
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: handshake, round-robin, stall, reset, saturation, bypass.
module tb_reg_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, wr_stall;
    logic        a_ready, b_ready, regwr;
    logic [4:0]  a_addr, b_addr, WriteAddr;
    logic [31:0] a_data, b_data, WriteData;
    logic [15:0] wr_count;
`ifdef REGARB_BYPASS_EN
    logic [4:0]  RsAddr, RtAddr;
    logic [31:0] RsData_in, RtData_in, RsData, RtData;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    reg_wr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .wr_stall  (wr_stall),
        .regwr     (regwr),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .wr_count  (wr_count)
`ifdef REGARB_BYPASS_EN
        ,
        .RsAddr    (RsAddr),
        .RtAddr    (RtAddr),
        .RsData_in (RsData_in),
        .RtData_in (RtData_in),
        .RsData    (RsData),
        .RtData    (RtData)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h5555_0000;
        #2;
        n_chk++; if (a_ready !== 1'b0) $display("FAIL rst_a_ready: got %b want 0", a_ready); else n_pass++;
        n_chk++; if (b_ready !== 1'b0) $display("FAIL rst_b_ready: got %b want 0", b_ready); else n_pass++;
        n_chk++; if (regwr !== 1'b0) $display("FAIL rst_regwr: got %b want 0", regwr); else n_pass++;
        n_chk++; if (WriteAddr !== 5'd0) $display("FAIL rst_waddr: got %h want 0", WriteAddr); else n_pass++;
        n_chk++; if (WriteData !== 32'd0) $display("FAIL rst_wdata: got %h want 0", WriteData); else n_pass++;
        n_chk++; if (wr_count !== 16'd0) $display("FAIL rst_count: got %h want 0", wr_count); else n_pass++;
        tick;
        reset = 1'b0; a_valid = 1'b0;
    endtask

    task automatic test_single_a;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h2333_2333;
        #1;
        n_chk++; if (a_ready !== 1'b1) $display("FAIL single_a_ready: got %b want 1", a_ready); else n_pass++;
        n_chk++; if (b_ready !== 1'b0) $display("FAIL single_b_ready: got %b want 0", b_ready); else n_pass++;
        tick;
        a_valid = 1'b0;
        n_chk++; if (regwr !== 1'b1) $display("FAIL single_regwr: got %b want 1", regwr); else n_pass++;
        n_chk++; if (WriteAddr !== 5'd3) $display("FAIL single_waddr: got %h want 3", WriteAddr); else n_pass++;
        n_chk++; if (WriteData !== 32'h2333_2333) $display("FAIL single_wdata: got %h want 23332333", WriteData); else n_pass++;
        tick;
        n_chk++; if (regwr !== 1'b0) $display("FAIL single_idle_regwr: got %b want 0", regwr); else n_pass++;
        n_chk++; if (WriteAddr !== 5'd3) $display("FAIL single_hold_waddr: got %h want 3", WriteAddr); else n_pass++;
        n_chk++; if (wr_count !== 16'd1) $display("FAIL single_count: got %0d want 1", wr_count); else n_pass++;
    endtask

    task automatic test_alternate;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        reset = 1'b1; #1; reset = 1'b0;
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hAAAA_0010;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hBBBB_0011;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (a_ready !== (i % 2 == 0)) $display("FAIL alt_a_ready[%0d]: got %b want %b", i, a_ready, (i % 2 == 0)); else n_pass++;
            n_chk++; if (b_ready !== (i % 2 == 1)) $display("FAIL alt_b_ready[%0d]: got %b want %b", i, b_ready, (i % 2 == 1)); else n_pass++;
            tick;
            exp_addr = (i % 2 == 0) ? 5'd10 : 5'd11;
            exp_data = (i % 2 == 0) ? 32'hAAAA_0010 : 32'hBBBB_0011;
            n_chk++; if (regwr !== 1'b1) $display("FAIL alt_regwr[%0d]: got %b want 1", i, regwr); else n_pass++;
            n_chk++; if (WriteAddr !== exp_addr) $display("FAIL alt_waddr[%0d]: got %h want %h", i, WriteAddr, exp_addr); else n_pass++;
            n_chk++; if (WriteData !== exp_data) $display("FAIL alt_wdata[%0d]: got %h want %h", i, WriteData, exp_data); else n_pass++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick;
        n_chk++; if (regwr !== 1'b0) $display("FAIL alt_end_regwr: got %b want 0", regwr); else n_pass++;
        n_chk++; if (wr_count !== 16'd4) $display("FAIL alt_count: got %0d want 4", wr_count); else n_pass++;
    endtask

    task automatic test_same_addr;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_1111;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_2222;
        #1;
        n_chk++; if (a_ready !== 1'b1) $display("FAIL same_a_ready: got %b want 1", a_ready); else n_pass++;
        n_chk++; if (b_ready !== 1'b0) $display("FAIL same_b_ready: got %b want 0", b_ready); else n_pass++;
        tick;
        a_valid = 1'b0;
        #1;
        n_chk++; if (b_ready !== 1'b1) $display("FAIL same_b_ready2: got %b want 1", b_ready); else n_pass++;
        tick;
        b_valid = 1'b0;
        n_chk++; if (WriteAddr !== 5'd9) $display("FAIL same_waddr: got %h want 9", WriteAddr); else n_pass++;
        n_chk++; if (WriteData !== 32'h0000_2222) $display("FAIL same_wdata: got %h want 2222", WriteData); else n_pass++;
        tick;
        tick;
        n_chk++; if (wr_count !== 16'd6) $display("FAIL same_count: got %0d want 6", wr_count); else n_pass++;
    endtask

    task automatic test_addr_zero;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
        #1;
        n_chk++; if (b_ready !== 1'b1) $display("FAIL zero_b_ready: got %b want 1", b_ready); else n_pass++;
        tick;
        b_valid = 1'b0;
        n_chk++; if (regwr !== 1'b0) $display("FAIL zero_regwr: got %b want 0", regwr); else n_pass++;
        tick;
        n_chk++; if (wr_count !== 16'd6) $display("FAIL zero_count: got %0d want 6", wr_count); else n_pass++;
    endtask

    task automatic test_stall;
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hCCCC_0012;
        tick;
        wr_stall = 1'b1;
        b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hDDDD_0013;
        #1;
        n_chk++; if (a_ready !== 1'b0) $display("FAIL stall_a_ready: got %b want 0", a_ready); else n_pass++;
        n_chk++; if (b_ready !== 1'b0) $display("FAIL stall_b_ready: got %b want 0", b_ready); else n_pass++;
        n_chk++; if (regwr !== 1'b1) $display("FAIL stall_inflight_regwr: got %b want 1", regwr); else n_pass++;
        tick;
        n_chk++; if (regwr !== 1'b0) $display("FAIL stall_regwr1: got %b want 0", regwr); else n_pass++;
        n_chk++; if (WriteAddr !== 5'd12) $display("FAIL stall_hold_waddr: got %h want 0c", WriteAddr); else n_pass++;
        tick;
        n_chk++; if (regwr !== 1'b0) $display("FAIL stall_regwr2: got %b want 0", regwr); else n_pass++;
        wr_stall = 1'b0;
        #1;
        n_chk++; if (b_ready !== 1'b1) $display("FAIL unstall_b_ready: got %b want 1", b_ready); else n_pass++;
        n_chk++; if (a_ready !== 1'b0) $display("FAIL unstall_a_ready: got %b want 0", a_ready); else n_pass++;
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        n_chk++; if (regwr !== 1'b1) $display("FAIL unstall_regwr: got %b want 1", regwr); else n_pass++;
        n_chk++; if (WriteAddr !== 5'd13) $display("FAIL unstall_waddr: got %h want 0d", WriteAddr); else n_pass++;
        tick;
        n_chk++; if (wr_count !== 16'd8) $display("FAIL stall_count: got %0d want 8", wr_count); else n_pass++;
    endtask

    task automatic test_reset_mid_write;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_0055;
        tick;
        n_chk++; if (WriteAddr !== 5'd5) $display("FAIL mid_pre_waddr: got %h want 5", WriteAddr); else n_pass++;
        b_valid = 1'b1; b_addr = 5'd14;
        #1;
        reset = 1'b1;
        #1;
        n_chk++; if (regwr !== 1'b0) $display("FAIL mid_regwr: got %b want 0", regwr); else n_pass++;
        n_chk++; if (WriteAddr !== 5'd0) $display("FAIL mid_waddr: got %h want 0", WriteAddr); else n_pass++;
        n_chk++; if (WriteData !== 32'd0) $display("FAIL mid_wdata: got %h want 0", WriteData); else n_pass++;
        n_chk++; if (wr_count !== 16'd0) $display("FAIL mid_count: got %0d want 0", wr_count); else n_pass++;
        n_chk++; if (a_ready !== 1'b0) $display("FAIL mid_a_ready: got %b want 0", a_ready); else n_pass++;
        #1;
        reset = 1'b0; a_addr = 5'd6; a_data = 32'h0000_0066;
        #1;
        n_chk++; if (a_ready !== 1'b1) $display("FAIL post_rst_a_ready: got %b want 1", a_ready); else n_pass++;
        n_chk++; if (b_ready !== 1'b0) $display("FAIL post_rst_b_ready: got %b want 0", b_ready); else n_pass++;
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        n_chk++; if (WriteAddr !== 5'd6) $display("FAIL first_grant_waddr: got %h want 6", WriteAddr); else n_pass++;
        tick;
    endtask

    task automatic test_saturate;
        #1; reset = 1'b1; #1; reset = 1'b0;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0000_0001;
        for (int i = 0; i < 65536; i++) tick;
        n_chk++; if (wr_count !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", wr_count); else n_pass++;
        n_chk++; if (regwr !== 1'b1) $display("FAIL sat_regwr: got %b want 1", regwr); else n_pass++;
        for (int i = 0; i < 4; i++) tick;
        n_chk++; if (wr_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", wr_count); else n_pass++;
    endtask

`ifdef REGARB_BYPASS_EN
    task automatic test_bypass;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7777_7777;
        tick;
        a_valid = 1'b0;
        RsAddr = 5'd7; RtAddr = 5'd8; RsData_in = 32'hAAAA_AAAA; RtData_in = 32'hBBBB_BBBB;
        #1;
        n_chk++; if (RsData !== 32'h7777_7777) $display("FAIL byp_rs_hit: got %h want 77777777", RsData); else n_pass++;
        n_chk++; if (RtData !== 32'hBBBB_BBBB) $display("FAIL byp_rt_miss: got %h want bbbbbbbb", RtData); else n_pass++;
        RsAddr = 5'd0; RtAddr = 5'd7;
        #1;
        n_chk++; if (RtData !== 32'h7777_7777) $display("FAIL byp_rt_hit: got %h want 77777777", RtData); else n_pass++;
        n_chk++; if (RsData !== 32'hAAAA_AAAA) $display("FAIL byp_rs_miss: got %h want aaaaaaaa", RsData); else n_pass++;
        tick;
        RsAddr = 5'd7;
        #1;
        n_chk++; if (RsData !== 32'hAAAA_AAAA) $display("FAIL byp_idle: got %h want aaaaaaaa", RsData); else n_pass++;
    endtask
`endif

    initial begin
        reset = 1'b1; wr_stall = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
`ifdef REGARB_BYPASS_EN
        RsAddr = '0; RtAddr = '0; RsData_in = '0; RtData_in = '0;
`endif
        test_reset;
        test_single_a;
        test_alternate;
        test_same_addr;
        test_addr_zero;
        test_stall;
        test_reset_mid_write;
        test_saturate;
`ifdef REGARB_BYPASS_EN
        test_bypass;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter: INIT_PRI, default 0, requester holding priority after reset (0 = A, 1 = B).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_valid  input  1  requester A has a write pending.
REQ-005 a_ready  output  1  A granted this cycle; transfer when a_valid & a_ready at rising edge.
REQ-006 a_addr  input  5  A destination register; a_data  input  32  A write value.
REQ-007 b_valid, b_ready, b_addr[4:0], b_data[31:0]: same roles as A, for requester B.
REQ-008 wr_stall  input  1  register file write port unavailable; blocks new grants.
REQ-009 regwr  output  1  write enable to register file, registered.
REQ-010 WriteAddr  output  5  registered write address; WriteData  output  32  registered write data.
REQ-011 wr_count  output  16  saturating count of committed (regwr=1) writes.

Function
REQ-012 a_ready SHALL be ~wr_stall & (pri==A | ~b_valid); b_ready SHALL be ~wr_stall & (pri==B | ~a_valid); combinational, never both 1 when both valid.
REQ-013 A transfer at edge N SHALL load WriteAddr/WriteData from the granted requester, with regwr=1 during cycle N+1 (one-cycle latency).
REQ-014 No transfer at edge N SHALL clear regwr for cycle N+1; WriteAddr/WriteData hold their previous values.
REQ-015 Transfer with address 0 SHALL complete the handshake but leave regwr=0 in cycle N+1 ($0 stays hardwired zero).
REQ-016 Round-robin: after a transfer from A, pri SHALL become B; after a transfer from B, pri SHALL become A; otherwise pri holds.
REQ-017 Both valid, same address same cycle: only priority holder granted; other requester's write lands one or more cycles later, so final register value is the later-granted data.
REQ-018 One transfer maximum per cycle; sustained throughput one write per cycle while wr_stall=0.
REQ-019 wr_stall=1 SHALL force a_ready=b_ready=0; the write already in the output stage SHALL still complete (regwr unaffected for that cycle).
REQ-020 wr_count SHALL increment by 1 at each edge where regwr=1 and SHALL saturate at 16'hFFFF.
REQ-021 Requester valid SHALL be permitted to drop without transfer; arbiter keeps no memory of unserved requests beyond pri.

Reset
REQ-022 reset=1 SHALL asynchronously force regwr=0, WriteAddr=0, WriteData=0, wr_count=0, pri=INIT_PRI.
REQ-023 While reset=1, a_ready=b_ready=0; a write in the output stage when reset asserts SHALL be discarded.
REQ-024 First grant possible at first rising edge after reset deasserts.

Configuration
REQ-025 Macro REGARB_BYPASS_EN SHALL add inputs RsAddr[4:0], RtAddr[4:0], RsData_in[31:0], RtData_in[31:0] and outputs RsData[31:0], RtData[31:0].
REQ-026 With REGARB_BYPASS_EN: RsData SHALL equal WriteData when regwr=1 and RsAddr==WriteAddr!=0, else RsData_in; RtData likewise; combinational.
REQ-027 Without REGARB_BYPASS_EN: those ports SHALL be absent and no bypass logic generated; all other behaviour identical.

Verification
REQ-028 Reset pulse mid-write (regwr=1, WriteAddr=5) -> regwr=0, WriteAddr=0, wr_count=0 immediately, no edge required.
REQ-029 Only A valid, a_addr=3, a_data=32'h23332333 -> a_ready=1, next cycle regwr=1, WriteAddr=3, WriteData=32'h23332333.
REQ-030 A and B valid continuously, INIT_PRI=0 -> grants alternate A,B,A,B; regwr=1 every cycle; wr_count=4 after four writes.
REQ-031 b_addr=0, b_data=32'hFFFFFFFF, B alone -> b_ready=1, next cycle regwr=0, wr_count unchanged.
REQ-032 wr_stall=1 with both valid -> a_ready=b_ready=0, regwr=0 from next cycle; deassert -> priority holder granted first.
REQ-033 wr_count preloaded near max via 65535 writes then one more -> wr_count stays 16'hFFFF; with REGARB_BYPASS_EN, RsAddr=WriteAddr=7 while regwr=1 -> RsData=WriteData.
